gen_key_events: RTL and testbench
=================================

// Module: gen_key_events
// PURPOSE
//  Multi-channel successor to the single-key pulse generator. Synchronises and
//  debounces NUM_KEYS active-low push-button inputs and emits one-cycle press,
//  release and long-press events per key, plus a debounced level. Sits between
//  board key pins and the control/menu logic; all outputs are in the clk domain.
// PARAMETERS
//  NUM_KEYS        4        number of independent key channels (>=1)
//  DB_WIDTH        22       width of the per-key debounce counter
//  DEBOUNCE_CYCLES 4000000  consecutive stable cycles required to accept a change (1..2^DB_WIDTH-1)
//  HOLD_WIDTH      28       width of the per-key hold counter
//  LONG_CYCLES     100000000 debounced-pressed cycles before key_long fires (1..2^HOLD_WIDTH-1)
//  REPEAT_CYCLES   10000000 auto-repeat period after long press (KEY_AUTO_REPEAT_EN only; >=1, <=LONG_CYCLES)
// PORTS
//  clk          in   1         single system clock
//  rst          in   1         synchronous, active-high reset
//  key_in_n     in   NUM_KEYS  raw asynchronous keys, 0 = pressed
//  key_level    out  NUM_KEYS  debounced state, 1 = pressed (registered)
//  key_press    out  NUM_KEYS  1-cycle pulse on debounced press
//  key_release  out  NUM_KEYS  1-cycle pulse on debounced release
//  key_long     out  NUM_KEYS  1-cycle pulse when hold reaches LONG_CYCLES
//  key_repeat   out  NUM_KEYS  1-cycle auto-repeat pulse (tied 0 without macro)
// BEHAVIOUR
//  - Reset: sync flops <= 1 (released), debounce/hold counters <= 0, state <= RELEASED;
//    all outputs 0. A key held through reset is reported as a new press after debounce.
//  - Channels fully independent; all logic per bit i, no cross-channel priority.
//  - Sync: 2-FF chain per key, s = ~key_in_n after 2 flops (s=1 pressed).
//  - Debounce: if s == key_level, db_cnt <= 0. Else db_cnt increments; on the cycle
//    db_cnt == DEBOUNCE_CYCLES-1 with s still differing, key_level <= s, db_cnt <= 0.
//    Any bounce back to key_level restarts the count. Pin edge to key_level edge:
//    2 + DEBOUNCE_CYCLES cycles for a clean edge.
//  - key_press/key_release registered, asserted in the same cycle key_level changes
//    (rising/falling); never both in one cycle; never consecutive pulses of the same kind.
//  - Per-key FSM (driven only by debounced level):
//    RELEASED: on press -> PRESSED, hold_cnt <= 1.
//    PRESSED : hold_cnt++; when hold_cnt == LONG_CYCLES pulse key_long, -> LONG,
//              rep_cnt <= 1; on release -> RELEASED, no key_long.
//    LONG    : hold_cnt saturates (no wrap); on release -> RELEASED.
//  - key_long exactly once per press; a release in the same cycle hold_cnt would reach
//    LONG_CYCLES wins: key_release pulses, key_long does not.
//  - key_release is issued on release from both PRESSED and LONG.
//  - Counter widths: compare with full-width constants; no counter ever wraps.
// CONFIGURATION
//  KEY_AUTO_REPEAT_EN defined: in LONG, rep_cnt increments each cycle; when it
//    reaches REPEAT_CYCLES pulse key_repeat and rep_cnt <= 1. First repeat is
//    REPEAT_CYCLES cycles after key_long. Release clears rep_cnt, no further pulses.
//  Not defined: rep_cnt logic absent, key_repeat driven constant 0, REPEAT_CYCLES unused.
// TESTING  (bench params: NUM_KEYS=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5)
//  1 key0 low at cycle 10, held -> key_level[0] rises and key_press[0] pulses at cycle 16;
//    key1 outputs stay 0.
//  2 key0 glitches low 3 cycles, high 1, low 3 -> no key_press, key_level[0] stays 0.
//  3 key0 held 30 cycles past press -> key_long[0] pulses once, 20 cycles after key_press;
//    release -> key_release[0] 6 cycles after pin edge.
//  4 key0 and key1 pressed same cycle, key1 released 10 cycles later -> both press pulses
//    same cycle; key1 release does not affect key0 long-press timing.
//  5 key0 held, rst asserted 1 cycle mid-hold -> all outputs 0 next cycle; key_press[0]
//    fires again 6 cycles after rst drops (pin still low).
//  6 KEY_AUTO_REPEAT_EN, key0 held 40 cycles past key_long -> key_repeat[0] at +5,+10,..,+40;
//    without macro key_repeat stays 0.

Source files
------------

// File: rtl/gen_key_events.sv
`default_nettype none
// ============================================================================
// Module   : gen_key_events
// Brief    : Per-key sync, debounce and press/release/long-press pulse
//            generator for NUM_KEYS active-low push-buttons.
//            Optional auto-repeat is built when KEY_AUTO_REPEAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module gen_key_events #(
    parameter int NUM_KEYS        = 4,
    parameter int DB_WIDTH        = 22,
    parameter int DEBOUNCE_CYCLES = 4000000,
    parameter int HOLD_WIDTH      = 28,
    parameter int LONG_CYCLES     = 100000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    localparam logic [1:0] c_st_released = 2'd0;
    localparam logic [1:0] c_st_pressed  = 2'd1;
    localparam logic [1:0] c_st_long     = 2'd2;

    localparam logic [DB_WIDTH-1:0]   c_db_last   = DB_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_WIDTH-1:0]   c_db_one    = DB_WIDTH'(1);
    localparam logic [HOLD_WIDTH-1:0] c_hold_long = HOLD_WIDTH'(LONG_CYCLES);
    localparam logic [HOLD_WIDTH-1:0] c_hold_one  = HOLD_WIDTH'(1);

    genvar i;
    generate
        for (i = 0; i < NUM_KEYS; i++) begin : g_key
            logic                  r_sync1;
            logic                  r_sync2;
            logic                  r_level;
            logic                  r_press;
            logic                  r_release;
            logic                  r_long;
            logic [DB_WIDTH-1:0]   r_db_cnt;
            logic [1:0]            r_state;
            logic [HOLD_WIDTH-1:0] r_hold_cnt;
            logic                  w_pressed;
            logic                  w_differs;
            logic                  w_accept;
            logic                  w_rise;
            logic                  w_fall;

            // Sync flops carry the raw active-low pin, so reset to 1 means released.
            assign w_pressed = ~r_sync2;
            assign w_differs = (w_pressed != r_level);
            assign w_accept  = w_differs && (r_db_cnt == c_db_last);
            assign w_rise    = w_accept && w_pressed;
            assign w_fall    = w_accept && !w_pressed;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1    <= 1'b1;
                    r_sync2    <= 1'b1;
                    r_level    <= 1'b0;
                    r_press    <= 1'b0;
                    r_release  <= 1'b0;
                    r_long     <= 1'b0;
                    r_db_cnt   <= '0;
                    r_state    <= c_st_released;
                    r_hold_cnt <= '0;
                end else begin
                    r_sync1   <= key_in_n[i];
                    r_sync2   <= r_sync1;
                    r_press   <= w_rise;
                    r_release <= w_fall;
                    r_long    <= 1'b0;

                    if (!w_differs || w_accept) begin
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + c_db_one;
                    end
                    if (w_accept) begin
                        r_level <= w_pressed;
                    end

                    // State follows the debounced edge in the same cycle it is accepted.
                    case (r_state)
                        c_st_released: begin
                            if (w_rise) begin
                                r_state    <= c_st_pressed;
                                r_hold_cnt <= c_hold_one;
                            end
                        end
                        c_st_pressed: begin
                            if (w_fall) begin
                                r_state    <= c_st_released;
                                r_hold_cnt <= '0;
                            end else if (r_hold_cnt == c_hold_long) begin
                                r_state <= c_st_long;
                                r_long  <= 1'b1;
                            end else begin
                                r_hold_cnt <= r_hold_cnt + c_hold_one;
                            end
                        end
                        c_st_long: begin
                            if (w_fall) begin
                                r_state    <= c_st_released;
                                r_hold_cnt <= '0;
                            end
                        end
                        default: begin
                            r_state    <= c_st_released;
                            r_hold_cnt <= '0;
                        end
                    endcase
                end
            end

            assign key_level[i]   = r_level;
            assign key_press[i]   = r_press;
            assign key_release[i] = r_release;
            assign key_long[i]    = r_long;

`ifdef KEY_AUTO_REPEAT_EN
            localparam logic [HOLD_WIDTH-1:0] c_rep_period = HOLD_WIDTH'(REPEAT_CYCLES);
            logic [HOLD_WIDTH-1:0] r_rep_cnt;
            logic                  r_repeat;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rep_cnt <= '0;
                    r_repeat  <= 1'b0;
                end else begin
                    r_repeat <= 1'b0;
                    if (r_state == c_st_pressed && !w_fall && r_hold_cnt == c_hold_long) begin
                        r_rep_cnt <= c_hold_one;
                    end else if (r_state == c_st_long && !w_fall) begin
                        if (r_rep_cnt == c_rep_period) begin
                            r_repeat  <= 1'b1;
                            r_rep_cnt <= c_hold_one;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + c_hold_one;
                        end
                    end else begin
                        r_rep_cnt <= '0;
                    end
                end
            end

            assign key_repeat[i] = r_repeat;
`else
            assign key_repeat[i] = 1'b0;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gen_key_events.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_key_events
// Brief    : Scoreboard bench for gen_key_events; expected pulse vectors are
//            queued with their cycle and compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen_key_events;

    localparam int NUM_KEYS = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_KEYS-1:0] key_in_n = '1;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;
    logic [NUM_KEYS-1:0] key_repeat;

    gen_key_events #(
        .NUM_KEYS        (NUM_KEYS),
        .DB_WIDTH        (8),
        .DEBOUNCE_CYCLES (4),
        .HOLD_WIDTH      (8),
        .LONG_CYCLES     (20),
        .REPEAT_CYCLES   (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in_n    (key_in_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_repeat  (key_repeat)
    );

    always #5 clk = ~clk;

    // Pulse vector layout: [1:0] press, [3:2] release, [5:4] long, [7:6] repeat.
    typedef struct packed {
        int         cyc;
        logic [7:0] ev;
    } ev_t;

    ev_t        sb[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_v;
    ev_t        ent;

    function automatic logic [7:0] obs();
        return {key_repeat, key_long, key_release, key_press};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input int c, input logic [7:0] v);
        ent.cyc = c;
        ent.ev  = v;
        sb.push_back(ent);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        key_in_n = '1;
        repeat (3) tick();
        checks++;
        if (key_level !== 2'b00) begin
            errors++;
            $display("FAIL reset_level got=%b exp=00", key_level);
        end
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_pulses got=%h exp=00", obs());
        end
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_press();
        int t0;
        t0 = cyc;
        key_in_n[0] = 1'b0;
        push(t0 + 6, 8'h01);
        push(t0 + 16, 8'h04);
        for (int k = 0; k < 20; k++) begin
            if (cyc == t0 + 10) key_in_n[0] = 1'b1;
            tick();
            exp_v = 8'h00;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                ent   = sb.pop_front();
                exp_v = ent.ev;
            end
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL press_events cyc=%0d got=%h exp=%h", cyc - t0, obs(), exp_v);
            end
            if (cyc == t0 + 5 || cyc == t0 + 6) begin
                checks++;
                if (key_level !== ((cyc == t0 + 6) ? 2'b01 : 2'b00)) begin
                    errors++;
                    $display("FAIL press_level cyc=%0d got=%b", cyc - t0, key_level);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int t0;
        t0 = cyc;
        for (int k = 0; k < 20; k++) begin
            key_in_n[0] = !((k < 3) || (k >= 4 && k < 7));
            tick();
            checks++;
            if (obs() !== 8'h00 || key_level !== 2'b00) begin
                errors++;
                $display("FAIL glitch cyc=%0d got_pulses=%h got_level=%b exp=00/00",
                         cyc - t0, obs(), key_level);
            end
        end
    endtask

    task automatic test_long();
        int t0;
        t0 = cyc;
        key_in_n[0] = 1'b0;
        push(t0 + 6, 8'h01);
        push(t0 + 26, 8'h10);
`ifdef KEY_AUTO_REPEAT_EN
        push(t0 + 31, 8'h40);
        push(t0 + 36, 8'h40);
        push(t0 + 41, 8'h40);
`endif
        push(t0 + 42, 8'h04);
        for (int k = 0; k < 46; k++) begin
            if (cyc == t0 + 36) key_in_n[0] = 1'b1;
            tick();
            exp_v = 8'h00;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                ent   = sb.pop_front();
                exp_v = ent.ev;
            end
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL long_events cyc=%0d got=%h exp=%h", cyc - t0, obs(), exp_v);
            end
            if (cyc == t0 + 41 || cyc == t0 + 42) begin
                checks++;
                if (key_level !== ((cyc == t0 + 41) ? 2'b01 : 2'b00)) begin
                    errors++;
                    $display("FAIL long_level cyc=%0d got=%b", cyc - t0, key_level);
                end
            end
        end
    endtask

    task automatic test_two_keys();
        int t0;
        t0 = cyc;
        key_in_n = 2'b00;
        push(t0 + 6, 8'h03);
        push(t0 + 16, 8'h08);
        push(t0 + 26, 8'h10);
`ifdef KEY_AUTO_REPEAT_EN
        push(t0 + 31, 8'h40);
        push(t0 + 36, 8'h40);
`endif
        push(t0 + 38, 8'h04);
        for (int k = 0; k < 42; k++) begin
            if (cyc == t0 + 10) key_in_n[1] = 1'b1;
            if (cyc == t0 + 32) key_in_n[0] = 1'b1;
            tick();
            exp_v = 8'h00;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                ent   = sb.pop_front();
                exp_v = ent.ev;
            end
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL two_keys cyc=%0d got=%h exp=%h", cyc - t0, obs(), exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int t0;
        t0 = cyc;
        key_in_n[0] = 1'b0;
        push(t0 + 6, 8'h01);
        push(t0 + 19, 8'h01);
        push(t0 + 28, 8'h04);
        for (int k = 0; k < 32; k++) begin
            if (cyc == t0 + 12) rst = 1'b1;
            if (cyc == t0 + 13) rst = 1'b0;
            if (cyc == t0 + 22) key_in_n[0] = 1'b1;
            tick();
            exp_v = 8'h00;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                ent   = sb.pop_front();
                exp_v = ent.ev;
            end
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL rst_mid_events cyc=%0d got=%h exp=%h", cyc - t0, obs(), exp_v);
            end
            if (cyc == t0 + 12 || cyc == t0 + 13 || cyc == t0 + 19) begin
                checks++;
                if (key_level !== ((cyc == t0 + 13) ? 2'b00 : 2'b01)) begin
                    errors++;
                    $display("FAIL rst_mid_level cyc=%0d got=%b", cyc - t0, key_level);
                end
            end
        end
    endtask

    task automatic test_repeat();
        int t0;
        t0 = cyc;
        key_in_n[0] = 1'b0;
        push(t0 + 6, 8'h01);
        push(t0 + 26, 8'h10);
`ifdef KEY_AUTO_REPEAT_EN
        for (int r = 1; r <= 8; r++) push(t0 + 26 + 5 * r, 8'h40);
`endif
        push(t0 + 68, 8'h04);
        for (int k = 0; k < 72; k++) begin
            if (cyc == t0 + 62) key_in_n[0] = 1'b1;
            tick();
            exp_v = 8'h00;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                ent   = sb.pop_front();
                exp_v = ent.ev;
            end
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL repeat_events cyc=%0d got=%h exp=%h", cyc - t0, obs(), exp_v);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_long();
        test_two_keys();
        test_reset_mid_hold();
        test_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
